eth_tx_frame_arbiter: RTL

// Frame-atomic round-robin arbiter sharing the single eth_rgmii MAC TX byte stream between N_SRC AXI-Stream frame sources.

---
 rtl/eth_arb_pkg.sv | 13 +
 rtl/eth_rr_pick.sv | 33 +++
 rtl/eth_tx_frame_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam int unsigned OVERSIZE_CNT_W = 16;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module eth_rr_pick
    import eth_arb_pkg::*;
#(
    parameter  int unsigned N_SRC = 2,
    localparam int unsigned IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_SRC-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
    always_comb begin
        int unsigned j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = int'(N_SRC); i >= 1; i--) begin
            j = (unsigned'(int'(ptr_i)) + unsigned'(i)) % N_SRC;
            if (req_i[IDX_W'(j)]) begin
                gnt_o             = '0;
                gnt_o[IDX_W'(j)]  = 1'b1;
                idx_o             = IDX_W'(j);
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter feeding one MAC TX byte stream from N_SRC sources.
module eth_tx_frame_arbiter
    import eth_arb_pkg::*;
#(
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_BEATS  = 1518,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_SRC*DATA_W-1:0]   s_tdata_i,
    input  logic [N_SRC-1:0]          s_tvalid_i,
    input  logic [N_SRC-1:0]          s_tlast_i,
    output logic [N_SRC-1:0]          s_tready_o,
    output logic [DATA_W-1:0]         m_tdata_o,
    output logic                      m_tvalid_o,
    output logic                      m_tlast_o,
    output logic                      m_tuser_o,
    input  logic                      m_tready_i,
    output logic [N_SRC-1:0]          grant_o,
    output logic                      busy_o,
    output logic [OVERSIZE_CNT_W-1:0] oversize_cnt_o
);

    localparam int unsigned IDX_W    = $clog2(N_SRC);
    localparam int unsigned BEAT_W   = $clog2(MAX_BEATS + 1);
    localparam int unsigned GAP_W    = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam int unsigned GAP_LAST = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
    localparam arb_state_e  EXIT_ST  = (IFG_CYCLES > 0) ? GAP : IDLE;

    arb_state_e                state_q, state_d;
    logic [N_SRC-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
    logic [OVERSIZE_CNT_W-1:0] ovs_cnt_q, ovs_cnt_d;

    logic [N_SRC-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              at_max;

    eth_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req_i (s_tvalid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Select the granted source's stream signals using the one-hot grant.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (grant_q[k]) begin
                sel_data  = s_tdata_i[k*DATA_W +: DATA_W];
                sel_valid = s_tvalid_i[k];
                sel_last  = s_tlast_i[k];
            end
        end
    end

    assign at_max = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));

    // Next-state, counters and stream outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ovs_cnt_d  = ovs_cnt_q;
        m_tdata_o  = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        m_tuser_o  = 1'b0;
        s_tready_o = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    ptr_d   = pick_idx;
                    state_d = FWD;
                end
            end
            FWD: begin
                m_tdata_o  = sel_data;
                m_tvalid_o = sel_valid;
                m_tlast_o  = sel_last | at_max;
                m_tuser_o  = at_max & ~sel_last;
                s_tready_o = grant_q & {N_SRC{m_tready_i}};
                if (sel_valid && m_tready_i) begin
                    if (sel_last) begin
                        state_d    = EXIT_ST;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                    end else if (at_max) begin
                        // Forced end of an oversize frame; the rest is drained.
                        state_d    = DRAIN;
                        beat_cnt_d = '0;
                        if (ovs_cnt_q != '1) begin
                            ovs_cnt_d = ovs_cnt_q + OVERSIZE_CNT_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            DRAIN: begin
                s_tready_o = grant_q;
                if (sel_valid && sel_last) begin
                    state_d = EXIT_ST;
                    grant_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(N_SRC - 1);
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ovs_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ovs_cnt_q  <= ovs_cnt_d;
        end
    end

    assign grant_o        = grant_q;
    assign busy_o         = (state_q != IDLE);
    assign oversize_cnt_o = ovs_cnt_q;

endmodule
